uart_pkt_rx: RTL

UART_PKT_RX -- requirements
Module: uart_pkt_rx

---
 rtl/uart_pkt_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_pkt_rx.sv
// Framed UART byte receiver: SOF, LEN, payload, XOR checksum.
// A good frame is buffered, then drained downstream on a valid/ready port.
module uart_pkt_rx #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic [2:0] fsm_state
);

    // Downstream handshake: a byte moves on every cycle where pkt_valid and
    // pkt_ready are both high; while pkt_valid=1 and pkt_ready=0, pkt_data,
    // pkt_last and pkt_len hold their values.

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, csum_q, wr_ptr, rd_ptr;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    buffer [MAX_LEN];

    logic       in_frame, timeout, len_ok, xfer, rd_last;
    logic       ok_d, err_d, drop_d;
    logic [1:0] code_d;

    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign timeout  = in_frame && !rx_valid && (tmo_cnt == TMO_LAST);
    assign len_ok   = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign rd_last  = (rd_ptr == len_q - 8'd1);

    assign pkt_valid = (state_q == S_DRAIN);
    assign pkt_data  = pkt_valid ? buffer[rd_ptr[AW-1:0]] : 8'd0;
    assign pkt_last  = pkt_valid && rd_last;
    assign pkt_len   = len_q;
    assign xfer      = pkt_valid && pkt_ready;
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        drop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        state_d = S_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    if (wr_ptr == len_q - 8'd1) state_d = S_CSUM;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                    state_d = S_IDLE;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        ok_d    = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    code_d  = 2'b11;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                drop_d = rx_valid;
                if (xfer && rd_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
            rx_drop   <= 1'b0;
            len_q     <= 8'd0;
            csum_q    <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            tmo_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
            rx_drop   <= drop_d;

            // Idle-gap counter only runs while a frame is being collected.
            if (!in_frame || rx_valid) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + 1'b1;

            if (state_q == S_LEN && rx_valid && len_ok) begin
                len_q  <= rx_data;
                csum_q <= rx_data;
                wr_ptr <= 8'd0;
            end
            if (state_q == S_PAYLOAD && rx_valid) begin
                csum_q <= csum_q ^ rx_data;
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (ok_d) rd_ptr <= 8'd0;
            else if (xfer) rd_ptr <= rd_last ? 8'd0 : rd_ptr + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && rx_valid) buffer[wr_ptr[AW-1:0]] <= rx_data;
    end

endmodule
